// File: rtl/neu_pu_if.sv
// Node execution unit bus: control inputs, neighbour costs and path outputs.
// Combinational bundle, no latency of its own.
// No backpressure; the node accepts en/ld/clr every cycle.
//
// master : array controller side (drives controls and neighbour costs)
// slave  : neu_pu side (drives path_cost/path_dir/path_mod/sweep_done/stable)
interface neu_pu_if #(
  parameter int CW  = 12,
  parameter int WW  = 4,
  parameter int NBR = 8
);
  logic                    en;
  logic                    clr;
  logic                    ld;
  logic [WW-1:0]           ld_weight;
  logic                    diag_en;
  logic [NBR*CW-1:0]       nbr_cost;
  logic [CW-1:0]           path_cost;
  logic [$clog2(NBR)-1:0]  path_dir;
  logic                    path_mod;
  logic                    sweep_done;
  logic                    stable;

  modport master (
    output en, clr, ld, ld_weight, diag_en, nbr_cost,
    input  path_cost, path_dir, path_mod, sweep_done, stable
  );

  modport slave (
    input  en, clr, ld, ld_weight, diag_en, nbr_cost,
    output path_cost, path_dir, path_mod, sweep_done, stable
  );
endinterface

// File: rtl/neu_pu.sv
// Grid path solver node: relaxes its best cost against LANES neighbours per cycle.
// Latency: cost/dir update at the edge after the relax cycle; flags registered one cycle.
// No backpressure; en=0 freezes the sweep, ld/clr restart it.
//
// Ports: clk, rst_n (sync, active-low), bus (neu_pu_if.slave):
//   in  en, clr, ld, ld_weight, diag_en, nbr_cost[NBR*CW]
//   out path_cost, path_dir, path_mod, sweep_done, stable
module neu_pu #(
  parameter int CW    = 12,
  parameter int WW    = 4,
  parameter int NBR   = 8,
  parameter int LANES = 1,
  parameter int PERP  = 2,
  parameter int DIAG  = 3
) (
  input logic   clk,
  input logic   rst_n,
  neu_pu_if.slave bus
);

  localparam int NG = NBR / LANES;
  localparam int PW = (NG > 1) ? $clog2(NG) : 1;
  localparam int DW = $clog2(NBR);
  localparam logic [CW-1:0]   MAX    = '1;
  localparam logic [WW-1:0]   WMAX   = '1;
  localparam logic [CW+1:0]   PERP_S = (CW+2)'(PERP);
  localparam logic [CW+1:0]   DIAG_S = (CW+2)'(DIAG);
  localparam logic [PW-1:0]   LAST   = PW'(NG - 1);

  logic [WW-1:0] weight;
  logic [CW-1:0] cost;
  logic [DW-1:0] dir;
  logic [PW-1:0] ptr;
  logic          chg;
  logic          path_mod_q;
  logic          sweep_done_q;
  logic          stable_q;

  logic          acc;
  logic          wrap;
  logic          upd;
  logic [CW-1:0] best;
  logic [DW-1:0] best_idx;
  logic [CW-1:0] adj;
  logic [CW+1:0] sum;
  logic [CW-1:0] trav;
  logic          is_diag;
  int            g;

  assign acc  = (weight != WMAX);
  assign wrap = (ptr == LAST);

  // Evaluate the current group; strict '<' keeps the lowest index on ties.
  always_comb begin
    best     = MAX;
    best_idx = '0;
    adj      = '0;
    sum      = '0;
    trav     = MAX;
    is_diag  = 1'b0;
    g        = 0;
    for (int i = 0; i < LANES; i++) begin
      g       = int'(ptr) * LANES + i;
      adj     = bus.nbr_cost[g*CW +: CW];
      // With 8-connectivity the odd indices are the diagonals.
      is_diag = (NBR == 8) && (g % 2 == 1);
      sum     = {2'b00, adj} + {{(CW+1-WW){1'b0}}, weight, 1'b0}
                + (is_diag ? DIAG_S : PERP_S);
      trav    = (sum >= {2'b00, MAX}) ? MAX : sum[CW-1:0];
      if (adj == MAX || (is_diag && !bus.diag_en)) trav = MAX;
      if (trav < best) begin
        best     = trav;
        best_idx = DW'(g);
      end
    end
  end

  assign upd = bus.en && acc && !bus.ld && !bus.clr && (best < cost);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      weight       <= WMAX;
      cost         <= MAX;
      dir          <= '0;
      ptr          <= '0;
      chg          <= 1'b0;
      path_mod_q   <= 1'b0;
      sweep_done_q <= 1'b0;
      stable_q     <= 1'b0;
    end else if (bus.ld || bus.clr) begin
      if (bus.ld) weight <= bus.ld_weight;
      // An inaccessible load wins over clr: a wall can never be a source.
      if (bus.ld && bus.ld_weight == WMAX) begin
        cost <= MAX;
        dir  <= '0;
      end else if (bus.clr) begin
        cost <= '0;
        dir  <= '0;
      end
      ptr          <= '0;
      chg          <= 1'b0;
      stable_q     <= 1'b0;
      path_mod_q   <= 1'b0;
      sweep_done_q <= 1'b0;
    end else if (!bus.en) begin
      path_mod_q   <= 1'b0;
      sweep_done_q <= 1'b0;
    end else if (!acc) begin
      cost         <= MAX;
      dir          <= '0;
      ptr          <= '0;
      chg          <= 1'b0;
      path_mod_q   <= 1'b0;
      sweep_done_q <= 1'b0;
      stable_q     <= 1'b1;
    end else begin
      if (upd) begin
        cost <= best;
        dir  <= best_idx;
      end
      path_mod_q   <= upd;
      sweep_done_q <= wrap;
      if (wrap) begin
        ptr      <= '0;
        // The wrap cycle's own update counts toward the finished sweep.
        stable_q <= !(chg || upd);
        chg      <= 1'b0;
      end else begin
        ptr <= ptr + PW'(1);
        chg <= chg || upd;
      end
    end
  end

  assign bus.path_cost  = cost;
  assign bus.path_dir   = dir;
  assign bus.path_mod   = path_mod_q;
  assign bus.sweep_done = sweep_done_q;
  assign bus.stable     = stable_q;

endmodule

// File: tb/tb_neu_pu.sv
module tb_neu_pu;

  logic clk = 1'b0;
  logic rst8_n, rst4_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  neu_pu_if #(.CW(12), .WW(4), .NBR(8)) if8 ();
  neu_pu_if #(.CW(12), .WW(4), .NBR(8)) if4 ();

  neu_pu #(.CW(12), .WW(4), .NBR(8), .LANES(1), .PERP(2), .DIAG(3)) d8 (
    .clk(clk), .rst_n(rst8_n), .bus(if8)
  );
  neu_pu #(.CW(12), .WW(4), .NBR(8), .LANES(4), .PERP(2), .DIAG(3)) d4 (
    .clk(clk), .rst_n(rst4_n), .bus(if4)
  );

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        ld;
    logic [3:0]  w;
    logic        diag;
    logic [95:0] nbr;
    int          rep;
    logic [11:0] cost;
    logic [2:0]  dir;
    logic        mod;
    logic        done;
    logic        stab;
  } vec_t;

  vec_t tv[$];

  localparam logic [11:0] MX = 12'hFFF;

  function automatic logic [95:0] nb8(input logic [11:0] c0, c1, c2, c3,
                                      input logic [11:0] c4, c5, c6, c7);
    return {c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  function automatic vec_t mkv(input logic rst_n, en, clr, ld, input logic [3:0] w,
                               input logic diag, input logic [95:0] nbr, input int rep,
                               input logic [11:0] cost, input logic [2:0] dir,
                               input logic mod, done, stab);
    vec_t v;
    v.rst_n = rst_n; v.en = en; v.clr = clr; v.ld = ld; v.w = w; v.diag = diag;
    v.nbr = nbr; v.rep = rep; v.cost = cost; v.dir = dir; v.mod = mod;
    v.done = done; v.stab = stab;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [95:0] all_m, pat, sat, dmask, zero, n5, es5, ne5;
    all_m = nb8(MX, MX, MX, MX, MX, MX, MX, MX);
    pat   = nb8(12'd10, 12'd8, MX, MX, MX, MX, MX, MX);
    sat   = nb8(12'hFFE, MX, MX, MX, MX, MX, MX, MX);
    dmask = nb8(MX, 12'd0, MX, MX, MX, MX, MX, MX);
    zero  = '0;
    n5    = nb8(12'd5, MX, MX, MX, MX, MX, MX, MX);
    es5   = nb8(MX, MX, 12'd5, MX, 12'd5, MX, MX, MX);
    ne5   = nb8(12'd5, MX, 12'd5, MX, MX, MX, MX, MX);

    //            rst en clr ld  w     dg nbr   rep cost     dir mod done stab
    tv.push_back(mkv(0, 1, 0, 0, 4'h0, 1, all_m, 1, MX,      0, 0, 0, 0)); // reset
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, all_m, 1, MX,      0, 0, 0, 1)); // inaccessible
    tv.push_back(mkv(1, 1, 0, 1, 4'h1, 1, all_m, 1, MX,      0, 0, 0, 0)); // ld w=1
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, pat,   1, 12'd14,  0, 1, 0, 0)); // N: 10+2+2
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, pat,   1, 12'd13,  1, 1, 0, 0)); // NE: 8+2+3
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, pat,   5, 12'd13,  1, 0, 0, 0));
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, pat,   1, 12'd13,  1, 0, 1, 0)); // wrap, changed
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, pat,   7, 12'd13,  1, 0, 0, 0));
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, pat,   1, 12'd13,  1, 0, 1, 1)); // 16th relax
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, pat,   1, 12'd13,  1, 0, 0, 1));
    tv.push_back(mkv(1, 1, 0, 1, 4'hF, 1, pat,   1, MX,      0, 0, 0, 0)); // ld F mid-sweep
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, pat,   1, MX,      0, 0, 0, 1));
    tv.push_back(mkv(1, 1, 0, 1, 4'hE, 1, all_m, 1, MX,      0, 0, 0, 0)); // ld w=14
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, sat,   7, MX,      0, 0, 0, 0)); // saturates
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, sat,   1, MX,      0, 0, 1, 1));
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 0, dmask, 8, MX,      0, 0, 1, 1)); // diag masked
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, dmask, 2, 12'd31,  1, 1, 0, 1)); // 0+28+3
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, dmask, 6, 12'd31,  1, 0, 1, 0));
    tv.push_back(mkv(1, 1, 1, 0, 4'h0, 1, zero,  1, 12'd0,   0, 0, 0, 0)); // clr
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, zero,  7, 12'd0,   0, 0, 0, 0));
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, zero,  1, 12'd0,   0, 0, 1, 1)); // 8 after clr
    tv.push_back(mkv(1, 1, 0, 1, 4'hF, 1, all_m, 1, MX,      0, 0, 0, 0));
    tv.push_back(mkv(1, 1, 1, 1, 4'h3, 1, all_m, 1, 12'd0,   0, 0, 0, 0)); // ld+clr ok
    tv.push_back(mkv(1, 1, 1, 1, 4'hF, 1, all_m, 1, MX,      0, 0, 0, 0)); // ld+clr wall
    tv.push_back(mkv(1, 1, 0, 1, 4'h2, 1, all_m, 1, MX,      0, 0, 0, 0));
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, all_m, 3, MX,      0, 0, 0, 0)); // ptr -> 3
    tv.push_back(mkv(1, 0, 0, 0, 4'h0, 1, zero,  5, MX,      0, 0, 0, 0)); // en=0 frozen
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, all_m, 4, MX,      0, 0, 0, 0));
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, all_m, 1, MX,      0, 0, 1, 1)); // wrap at ptr 7
    tv.push_back(mkv(1, 1, 0, 1, 4'h2, 1, all_m, 1, MX,      0, 0, 0, 0));
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, all_m, 3, MX,      0, 0, 0, 0));
    tv.push_back(mkv(0, 1, 0, 0, 4'h0, 1, all_m, 1, MX,      0, 0, 0, 0)); // reset at ptr 3
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, all_m, 1, MX,      0, 0, 0, 1)); // weight reset
    tv.push_back(mkv(1, 1, 0, 1, 4'h2, 1, n5,    1, MX,      0, 0, 0, 0));
    tv.push_back(mkv(1, 1, 0, 0, 4'h0, 1, n5,    1, 12'd11,  0, 1, 0, 0)); // 5+4+2

    rst8_n = 1'b0; rst4_n = 1'b0;
    if8.en = 1'b1; if8.clr = 1'b0; if8.ld = 1'b0; if8.ld_weight = '0;
    if8.diag_en = 1'b1; if8.nbr_cost = all_m;
    if4.en = 1'b1; if4.clr = 1'b0; if4.ld = 1'b0; if4.ld_weight = '0;
    if4.diag_en = 1'b1; if4.nbr_cost = all_m;

    for (int k = 0; k < tv.size(); k++) begin
      for (int r = 0; r < tv[k].rep; r++) begin
        rst8_n        = tv[k].rst_n;
        if8.en        = tv[k].en;
        if8.clr       = tv[k].clr;
        if8.ld        = tv[k].ld;
        if8.ld_weight = tv[k].w;
        if8.diag_en   = tv[k].diag;
        if8.nbr_cost  = tv[k].nbr;
        tick();
      end
      chk($sformatf("v%0d cost", k),   32'(if8.path_cost),  32'(tv[k].cost));
      chk($sformatf("v%0d dir", k),    32'(if8.path_dir),   32'(tv[k].dir));
      chk($sformatf("v%0d mod", k),    32'(if8.path_mod),   32'(tv[k].mod));
      chk($sformatf("v%0d done", k),   32'(if8.sweep_done), 32'(tv[k].done));
      chk($sformatf("v%0d stable", k), 32'(if8.stable),     32'(tv[k].stab));
    end

    // LANES=4: two groups per sweep, cross-group tie on E/S.
    rst4_n = 1'b0;
    tick();
    chk("l4 reset cost", 32'(if4.path_cost), 32'(MX));
    chk("l4 reset stable", 32'(if4.stable), 32'd0);
    rst4_n = 1'b1; if4.ld = 1'b1; if4.ld_weight = 4'h0; if4.nbr_cost = es5;
    tick();
    if4.ld = 1'b0;
    tick();
    chk("l4 g0 cost", 32'(if4.path_cost), 32'd7);
    chk("l4 g0 dir", 32'(if4.path_dir), 32'd2);
    chk("l4 g0 mod", 32'(if4.path_mod), 32'd1);
    chk("l4 g0 done", 32'(if4.sweep_done), 32'd0);
    tick();
    chk("l4 g1 dir", 32'(if4.path_dir), 32'd2);
    chk("l4 g1 mod", 32'(if4.path_mod), 32'd0);
    chk("l4 g1 done", 32'(if4.sweep_done), 32'd1);
    chk("l4 g1 stable", 32'(if4.stable), 32'd0);
    tick();
    chk("l4 g0b done", 32'(if4.sweep_done), 32'd0);
    tick();
    chk("l4 g1b done", 32'(if4.sweep_done), 32'd1);
    chk("l4 g1b stable", 32'(if4.stable), 32'd1);

    // In-group tie: N and E both 5 in group 0, N (index 0) wins.
    if4.ld = 1'b1; if4.ld_weight = 4'hF;
    tick();
    if4.ld_weight = 4'h0;
    tick();
    chk("l4 reload cost", 32'(if4.path_cost), 32'(MX));
    if4.ld = 1'b0; if4.nbr_cost = ne5;
    tick();
    chk("l4 tie cost", 32'(if4.path_cost), 32'd7);
    chk("l4 tie dir", 32'(if4.path_dir), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/neu_pu.md
# neu_pu

Parametrised node execution unit for the grid path solver. It generalises the original single-neighbour-per-cycle node cell. Each instance holds one grid node's weight, best known cost and back-pointer direction, and relaxes that cost against its neighbours' costs:

- over configurable cost/weight widths;
- with 4- or 8-connectivity;
- with several neighbours compared per cycle.

It adds saturating arithmetic, a runtime diagonal mask, and per-node sweep/stability flags that the array controller ANDs together to detect convergence.

## Interface
- CW, 12: cost width; all-ones (MAX) means unreachable
- WW, 4: weight width; weight all-ones means inaccessible; CW > WW+2 required
- NBR, 8: neighbour count, 4 or 8; index 0 = N, then clockwise (NBR=8: N,NE,E,SE,S,SW,W,NW; NBR=4: N,E,S,W)
- LANES, 1: neighbours evaluated per cycle; power of two dividing NBR
- PERP, 2: step cost for cardinal moves
- DIAG, 3: step cost for diagonal moves (NBR=8 only)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- en  in  1  relaxation enable; low freezes cost/dir/ptr
- clr  in  1  make this node the source: cost to 0
- ld  in  1  load weight
- ld_weight  in  WW  weight to load
- diag_en  in  1  NBR=8: 0 masks diagonal neighbours (ignored when NBR=4)
- nbr_cost  in  NBR*CW  neighbour costs, neighbour i at bits [i*CW +: CW]
- path_cost  out  CW  current best cost
- path_dir  out  clog2(NBR)  neighbour index the best cost came from
- path_mod  out  1  registered; high the cycle after cost was lowered
- sweep_done  out  1  one-cycle pulse when the last group of a sweep has been evaluated
- stable  out  1  last complete sweep produced no change

## Operation
- State registers: weight, cost, dir, ptr (group index, 0..NBR/LANES-1), a sweep-change flag, path_mod, sweep_done, stable.
- Accessible means weight != all-ones.
- **Relax cycle** occurs when rst_n=1, ld=0, clr=0, en=1 and the node is accessible. Group ptr covers neighbours ptr*LANES .. ptr*LANES+LANES-1. For each lane i:
  - step = PERP if i is cardinal, DIAG if diagonal.
  - travel_i = adj_i + (weight<<1) + step, computed at CW+2 bits and saturated to MAX.
  - travel_i is forced to MAX if adj_i == MAX.
  - travel_i is forced to MAX if i is diagonal and diag_en=0.
- best = minimum travel_i; ties go to the lowest index.
- If best < cost: cost<=best, dir<=index, path_mod<=1, sweep-change flag set. Otherwise cost/dir hold and path_mod<=0.
- ptr increments and wraps to 0 after NBR/LANES-1. On the wrap cycle:
  - sweep_done<=1;
  - stable<=1 if no change occurred in the completed sweep (including the wrap cycle itself), else stable<=0;
  - the sweep-change flag clears.
- **Inaccessible node**: cost held at MAX, dir 0, ptr held at 0, path_mod 0, sweep_done 0, stable 1.
- **en=0**: all state holds; path_mod and sweep_done go to 0.
- **ld** (priority over relax): weight<=ld_weight, ptr<=0, sweep-change flag cleared, stable<=0.
  - If the loaded weight is inaccessible, cost<=MAX and dir<=0.
- **clr** (priority over relax): cost<=0, dir<=0, ptr<=0, stable<=0.
- **ld and clr together**: both take effect. If the loaded weight is inaccessible, cost becomes MAX; otherwise cost becomes 0.
- **Reset** (rst_n=0, overrides everything): cost=MAX, dir=0, ptr=0, weight=all-ones, path_mod=0, sweep_done=0, stable=0.
  - Reset in mid-sweep discards the partial sweep.

## Timing
- Throughput: one group per cycle; a full sweep takes NBR/LANES relax cycles.
- nbr_cost is sampled combinationally in the relax cycle. path_cost/path_dir update at the next clk edge.
- path_mod, sweep_done and stable are registered; all are valid the cycle after the causing edge.
- stable first asserts after one complete change-free sweep following ld/clr/reset. Minimum latency from clr is NBR/LANES cycles.
- The source node stays at cost 0: travel is always ≥ PERP, so no update can occur.

## Test plan
- Reset, defaults (CW=12, WW=4, NBR=8, LANES=1): rst_n=0 one cycle -> path_cost=0xFFF, path_dir=0, stable=0, node inaccessible, stable=1 the cycle after rst_n=1.
- Perpendicular vs diagonal: weight=1, N=10, NE=8, all others 0xFFF.
  - N cycle -> cost=14 (10+2+2), dir=0.
  - NE cycle -> cost=13 (8+2+3), dir=1, path_mod pulses twice.
  - Next sweep change-free -> stable=1 after 16 relax cycles total.
- Saturation and mask:
  - weight=14, N=0xFFE, others MAX -> cost stays 0xFFF.
  - diag_en=0 with NE=0 and others MAX -> no update.
- LANES=4, tie-break: E=S=5, others MAX, weight=0 -> cost=7, dir=2 (E wins tie), sweep_done every 2 cycles.
- Source and load:
  - clr -> cost=0, stable=1 after 8 cycles.
  - ld 4'hF mid-sweep -> cost=0xFFF, stable=1 the following cycle.
  - ld+clr together with accessible weight -> cost=0.
- en gating and mid-sweep reset:
  - en=0 for 5 cycles while neighbour costs drop -> no change, ptr frozen.
  - rst_n=0 at ptr=3 -> ptr=0, cost=0xFFF.
